// File: rtl/cdb_arbiter.sv
// Two-wide CDB arbiter: picks up to two completed FU results per cycle with rotating priority.
// Latency: grant in cycle N -> registered broadcast on cdb1/cdb2 in cycle N+1.
// Backpressure: fu_available drops for a source holding an ungranted result; flush forces it high.
module cdb_arbiter #(
    parameter int NUM_SRC  = 6,
    parameter int PRF_SIZE = 64,
    parameter int ROB_SIZE = 32,
    localparam int PW = $clog2(PRF_SIZE),
    localparam int RW = $clog2(ROB_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic [NUM_SRC*PW-1:0] src_tag,
    input  logic [NUM_SRC*64-1:0] src_data,
    input  logic [NUM_SRC*RW-1:0] src_rob_idx,
    output logic [NUM_SRC-1:0]    src_grant,
    output logic [NUM_SRC-1:0]    fu_available,
    output logic                  cdb1_valid,
    output logic [PW-1:0]         cdb1_tag,
    output logic [63:0]           cdb1_data,
    output logic [RW-1:0]         cdb1_rob_idx,
    output logic                  cdb2_valid,
    output logic [PW-1:0]         cdb2_tag,
    output logic [63:0]           cdb2_data,
    output logic [RW-1:0]         cdb2_rob_idx
);
    localparam int SW = $clog2(NUM_SRC);

    logic [SW-1:0] ptr;
    logic [SW-1:0] a_idx, b_idx, idx;
    logic [SW:0]   sum;
    logic          a_vld, b_vld;
    logic          arb_en;

    function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] i);
        return (i == SW'(NUM_SRC - 1)) ? '0 : i + SW'(1);
    endfunction

    // Scan from ptr with wrap; first two valid sources become slots A and B.
    always_comb begin
        a_vld = 1'b0;
        b_vld = 1'b0;
        a_idx = '0;
        b_idx = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sum = {1'b0, ptr} + (SW+1)'(k);
            if (sum >= (SW+1)'(NUM_SRC))
                sum = sum - (SW+1)'(NUM_SRC);
            idx = sum[SW-1:0];
            if (src_valid[idx]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = idx;
                end else if (!b_vld) begin
                    b_vld = 1'b1;
                    b_idx = idx;
                end
            end
        end
    end

    assign arb_en = reset & ~flush;

    always_comb begin
        src_grant = '0;
        if (arb_en) begin
            if (a_vld) src_grant[a_idx] = 1'b1;
            if (b_vld) src_grant[b_idx] = 1'b1;
        end
    end

    always_comb begin
        if (!reset)
            fu_available = ~src_valid;
        else if (flush)
            fu_available = '1;
        else
            fu_available = ~src_valid | src_grant;
    end

    always_ff @(posedge clock) begin
        if (!arb_en) begin
            cdb1_valid   <= 1'b0;
            cdb1_tag     <= '0;
            cdb1_data    <= '0;
            cdb1_rob_idx <= '0;
            cdb2_valid   <= 1'b0;
            cdb2_tag     <= '0;
            cdb2_data    <= '0;
            cdb2_rob_idx <= '0;
            if (!reset)
                ptr <= '0;
        end else begin
            cdb1_valid   <= a_vld;
            cdb1_tag     <= a_vld ? src_tag[a_idx*PW +: PW]     : '0;
            cdb1_data    <= a_vld ? src_data[a_idx*64 +: 64]    : '0;
            cdb1_rob_idx <= a_vld ? src_rob_idx[a_idx*RW +: RW] : '0;
            cdb2_valid   <= b_vld;
            cdb2_tag     <= b_vld ? src_tag[b_idx*PW +: PW]     : '0;
            cdb2_data    <= b_vld ? src_data[b_idx*64 +: 64]    : '0;
            cdb2_rob_idx <= b_vld ? src_rob_idx[b_idx*RW +: RW] : '0;
            // Priority rotates past the last source served this cycle.
            if (b_vld)
                ptr <= next_idx(b_idx);
            else if (a_vld)
                ptr <= next_idx(a_idx);
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued at grant time and popped a cycle later.
module tb_cdb_arbiter;
    localparam int N  = 6;
    localparam int PW = 6;
    localparam int RW = 5;

    typedef struct packed {
        logic          v1;
        logic [PW-1:0] t1;
        logic [63:0]   d1;
        logic [RW-1:0] r1;
        logic          v2;
        logic [PW-1:0] t2;
        logic [63:0]   d2;
        logic [RW-1:0] r2;
    } bcast_t;

    logic clock = 1'b0;
    logic reset, flush;
    logic [N-1:0]    src_valid;
    logic [N*PW-1:0] src_tag;
    logic [N*64-1:0] src_data;
    logic [N*RW-1:0] src_rob_idx;
    logic [N-1:0]    src_grant, fu_available;
    logic            cdb1_valid, cdb2_valid;
    logic [PW-1:0]   cdb1_tag, cdb2_tag;
    logic [63:0]     cdb1_data, cdb2_data;
    logic [RW-1:0]   cdb1_rob_idx, cdb2_rob_idx;

    logic [PW-1:0] s_tag  [N];
    logic [63:0]   s_data [N];
    logic [RW-1:0] s_rob  [N];

    bcast_t sb_q[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    always_comb begin
        src_tag = '0;
        src_data = '0;
        src_rob_idx = '0;
        for (int i = 0; i < N; i++) begin
            src_tag[i*PW +: PW]     = s_tag[i];
            src_data[i*64 +: 64]    = s_data[i];
            src_rob_idx[i*RW +: RW] = s_rob[i];
        end
    end

    cdb_arbiter #(.NUM_SRC(N), .PRF_SIZE(64), .ROB_SIZE(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_rob_idx(src_rob_idx), .src_grant(src_grant), .fu_available(fu_available),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .cdb1_rob_idx(cdb1_rob_idx),
        .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag), .cdb2_data(cdb2_data),
        .cdb2_rob_idx(cdb2_rob_idx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: check combinational grant/available, queue the expected
    // broadcast built from slots a/b (-1 = empty), clock, then check it and ptr.
    task automatic step(input string name, input logic [N-1:0] eg, input logic [N-1:0] ea,
                        input int a, input int b, input int eptr);
        bcast_t e, got;
        #1;
        check({name, ".grant"}, 64'(src_grant), 64'(eg));
        check({name, ".avail"}, 64'(fu_available), 64'(ea));
        e = '0;
        if (a >= 0) begin
            e.v1 = 1'b1; e.t1 = s_tag[a]; e.d1 = s_data[a]; e.r1 = s_rob[a];
        end
        if (b >= 0) begin
            e.v2 = 1'b1; e.t2 = s_tag[b]; e.d2 = s_data[b]; e.r2 = s_rob[b];
        end
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s.queue observed=empty expected=entry", name);
        end else begin
            got = sb_q.pop_front();
            check({name, ".cdb1_valid"}, 64'(cdb1_valid),   64'(got.v1));
            check({name, ".cdb1_tag"},   64'(cdb1_tag),     64'(got.t1));
            check({name, ".cdb1_data"},  cdb1_data,         got.d1);
            check({name, ".cdb1_rob"},   64'(cdb1_rob_idx), 64'(got.r1));
            check({name, ".cdb2_valid"}, 64'(cdb2_valid),   64'(got.v2));
            check({name, ".cdb2_tag"},   64'(cdb2_tag),     64'(got.t2));
            check({name, ".cdb2_data"},  cdb2_data,         got.d2);
            check({name, ".cdb2_rob"},   64'(cdb2_rob_idx), 64'(got.r2));
        end
        check({name, ".ptr"}, 64'(dut.ptr), 64'(eptr));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            s_tag[i]  = PW'(i + 40);
            s_data[i] = 64'h1111_0000 + 64'(i);
            s_rob[i]  = RW'(i + 10);
        end
        reset = 1'b0;
        flush = 1'b0;
        src_valid = '1;

        // Reset held two cycles with every source requesting.
        step("rst0", 6'b000000, 6'b000000, -1, -1, 0);
        step("rst1", 6'b000000, 6'b000000, -1, -1, 0);

        // Full contention from ptr=0: pairs rotate {0,1},{2,3},{4,5},{0,1}.
        reset = 1'b1;
        step("cont0", 6'b000011, 6'b000011, 0, 1, 2);
        step("cont1", 6'b001100, 6'b001100, 2, 3, 4);
        step("cont2", 6'b110000, 6'b110000, 4, 5, 0);
        step("cont3", 6'b000011, 6'b000011, 0, 1, 2);

        // Single result on fu1 adder.
        src_valid = 6'b000010;
        s_tag[1] = 6'd1; s_data[1] = 64'd832; s_rob[1] = 5'd0;
        step("single", 6'b000010, 6'b111111, 1, -1, 2);

        // Idle cycle: broadcast lasts one cycle, ptr holds.
        src_valid = '0;
        step("idle", 6'b000000, 6'b111111, -1, -1, 2);

        // Lone source 5 moves ptr back to 0.
        src_valid = 6'b100000;
        step("solo5", 6'b100000, 6'b111111, 5, -1, 0);

        // Dual result from src0 and src4.
        src_valid = 6'b010001;
        s_tag[0] = 6'h20; s_data[0] = 64'h3_0000;  s_rob[0] = 5'd2;
        s_tag[4] = 6'h10; s_data[4] = 64'h45_0000; s_rob[4] = 5'd3;
        step("dual", 6'b010001, 6'b111111, 0, 4, 5);

        // Wrap: ptr=5, sources 5 and 0.
        src_valid = 6'b100001;
        step("wrap", 6'b100001, 6'b111111, 5, 0, 1);

        // Flush squashes grants and broadcasts, ptr unchanged.
        src_valid = 6'b001100;
        flush = 1'b1;
        step("flush", 6'b000000, 6'b111111, -1, -1, 1);
        flush = 1'b0;
        step("postflush", 6'b001100, 6'b111111, 2, 3, 4);

        // Reset mid-stream: pending source waits, then is served after release.
        src_valid = 6'b000001;
        reset = 1'b0;
        step("midrst", 6'b000000, 6'b111110, -1, -1, 0);
        reset = 1'b1;
        step("postrst", 6'b000001, 6'b111111, 0, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
